// File: rtl/color_fsm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// color_fsm_pkg : colour/command encodings and next-colour helpers
// Rev 1.0
// ============================================================================
package color_fsm_pkg;

  typedef enum logic [1:0] {
    BLUE  = 2'd0,
    RED   = 2'd1,
    GREEN = 2'd2
  } color_state_t;

  typedef enum logic [1:0] {
    NOP  = 2'd0,
    FWD  = 2'd1,
    REV  = 2'd2,
    JUMP = 2'd3
  } cmd_t;

  function automatic color_state_t fwd_of(color_state_t s);
    case (s)
      BLUE:    return RED;
      RED:     return GREEN;
      default: return BLUE;
    endcase
  endfunction

  function automatic color_state_t rev_of(color_state_t s);
    case (s)
      BLUE:    return GREEN;
      GREEN:   return RED;
      default: return BLUE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/color_fsm_ctrl_if.sv
`default_nettype none
// ============================================================================
// color_fsm_ctrl_if : command port and status outputs of color_fsm_ctrl
// Rev 1.0
// ============================================================================
interface color_fsm_ctrl_if #(
  parameter int CNT_W = 8,
  parameter int OUT_W = 2
);
  logic             cmd_valid;
  logic [1:0]       cmd;
  logic             cmd_ready;
  logic             clr_count;
  logic [OUT_W-1:0] out;
  logic [1:0]       state;
  logic [CNT_W-1:0] dwell;
  logic [CNT_W-1:0] count;
  logic             count_sat;

  modport master (
    output cmd_valid, cmd, clr_count,
    input  cmd_ready, out, state, dwell, count, count_sat
  );

  modport slave (
    input  cmd_valid, cmd, clr_count,
    output cmd_ready, out, state, dwell, count, count_sat
  );
endinterface
`default_nettype wire

// File: rtl/color_fsm_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// sat_counter : up-counter with synchronous clear, saturates at all ones
// Rev 1.0
// ============================================================================
module sat_counter #(
  parameter int W = 8
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         clr,
  input  wire logic         inc,
  output logic      [W-1:0] cnt
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt = r_cnt;
endmodule
`default_nettype wire

// File: rtl/color_fsm_ctrl.sv
`default_nettype none
// ============================================================================
// color_fsm_ctrl : three-colour Moore FSM with dwell-gated FWD/REV commands
// Rev 1.0
// ============================================================================
module color_fsm_ctrl
  import color_fsm_pkg::*;
#(
  parameter int               CNT_W       = 8,
  parameter int               MIN_DWELL   = 4,
  parameter int               OUT_W       = 2,
  parameter logic [OUT_W-1:0] BLUE_CODE   = OUT_W'(1),
  parameter logic [OUT_W-1:0] RED_CODE    = OUT_W'(2),
  parameter logic [OUT_W-1:0] GREEN_CODE  = OUT_W'(3),
  parameter color_state_t     RESET_STATE = RED,
  parameter color_state_t     COUNT_STATE = RED
) (
  input wire logic        clk,
  input wire logic        rst,
  color_fsm_ctrl_if.slave bus
);
  color_state_t     r_state;
  color_state_t     w_next;
  cmd_t             w_cmd;
  logic [CNT_W-1:0] w_dwell;
  logic [CNT_W-1:0] w_count;
  logic [OUT_W-1:0] w_out;
  logic             w_legal, w_thr_ok, w_ready, w_jump, w_move, w_dwell_clr;

  assign w_cmd   = cmd_t'(bus.cmd);
  assign w_legal = (r_state == BLUE) || (r_state == RED) || (r_state == GREEN);

  // MIN_DWELL of 1 makes the threshold zero, so the compare is dropped entirely.
  generate
    if (MIN_DWELL <= 1) begin : g_ready_always
      assign w_thr_ok = 1'b1;
    end else begin : g_ready_thr
      localparam logic [CNT_W-1:0] c_READY_THR = CNT_W'(MIN_DWELL - 1);
      assign w_thr_ok = (w_dwell >= c_READY_THR);
    end
  endgenerate

  assign w_ready = w_legal && w_thr_ok;
  assign w_jump  = bus.cmd_valid && (w_cmd == JUMP);
  assign w_move  = bus.cmd_valid && w_ready && ((w_cmd == FWD) || (w_cmd == REV));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RESET_STATE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      BLUE, RED, GREEN: begin
        if (w_jump) begin
          w_next = RESET_STATE;
        end else if (w_move) begin
          w_next = (w_cmd == FWD) ? fwd_of(r_state) : rev_of(r_state);
        end
      end
      default: w_next = RESET_STATE;
    endcase
  end

  always_comb begin
    w_out = '0;
    case (r_state)
      BLUE:    w_out = BLUE_CODE;
      RED:     w_out = RED_CODE;
      GREEN:   w_out = GREEN_CODE;
      default: w_out = '0;
    endcase
  end

  // JUMP restarts the dwell window even when it lands on the current state.
  assign w_dwell_clr = (w_next != r_state) || w_jump;

  sat_counter #(.W(CNT_W)) u_dwell (
    .clk (clk),
    .rst (rst),
    .clr (w_dwell_clr),
    .inc (1'b1),
    .cnt (w_dwell)
  );

  sat_counter #(.W(CNT_W)) u_count (
    .clk (clk),
    .rst (rst),
    .clr (bus.clr_count),
    .inc (r_state == COUNT_STATE),
    .cnt (w_count)
  );

  assign bus.cmd_ready = w_ready;
  assign bus.out       = w_out;
  assign bus.state     = r_state;
  assign bus.dwell     = w_dwell;
  assign bus.count     = w_count;
  assign bus.count_sat = &w_count;
endmodule
`default_nettype wire
